// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder. A single full_adder is reused once per clock,
// LSB first. Operands are taken on an accepted start, and the registered
// sum/carry hold until the next add completes.

// One-bit full adder. This is the only adder logic in the block.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  input  logic             C_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] S_out,
  output logic             C_out
);
  // Counter only has to reach WIDTH-1, and WIDTH is at least 2.
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr, b_sr, sum_sr;
  logic             carry;
  logic             busy_q, done_q, c_q;
  logic [WIDTH-1:0] s_q;

  logic             fa_s, fa_co;
  logic [WIDTH-1:0] sum_next;
  logic             accept, last_bit;

  // Shared adder: bit 0 of each operand shifter plus the running carry.
  full_adder u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // New sum bits enter at the MSB, so after WIDTH shifts bit 0 sits at the LSB.
  assign sum_next = {fa_s, sum_sr[WIDTH-1:1]};
  assign accept   = (state == IDLE) && start_in;
  assign last_bit = (state == RUN) && (cnt == LAST);

  // FSM: start is only looked at in IDLE, so a start in RUN is simply dropped.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (start_in) state <= RUN;
        RUN:     if (cnt == LAST) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Bit counter: cleared on accept, counts processed bits while running.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= '0;
    end else if (state == RUN) begin
      cnt <= last_bit ? '0 : cnt + CW'(1);
    end
  end

  // Operand and carry datapath: load on accept, shift right while running.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      a_sr  <= '0;
      b_sr  <= '0;
      carry <= 1'b0;
    end else if (accept) begin
      a_sr  <= A_in;
      b_sr  <= B_in;
      carry <= C_in;
    end else if (state == RUN) begin
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      carry <= fa_co;
    end
  end

  // Internal sum shifter collects one FA sum bit per running edge.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      sum_sr <= '0;
    end else if (state == RUN) begin
      sum_sr <= sum_next;
    end
  end

  // Status flags: busy mirrors the next state, done pulses on the MSB edge.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= last_bit;
      if (accept)        busy_q <= 1'b1;
      else if (last_bit) busy_q <= 1'b0;
    end
  end

  // Result registers update only on the completing edge and hold otherwise.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      s_q <= '0;
      c_q <= 1'b0;
    end else if (last_bit) begin
      s_q <= sum_next;
      c_q <= fa_co;
    end
  end

  assign busy_out = busy_q;
  assign done_out = done_q;
  assign S_out    = s_q;
  assign C_out    = c_q;
endmodule
